// File: rtl/eclair_alu_pkg.sv
// Shared encodings for driving alu_16 and the mul_div_seq state type.
package eclair_alu_pkg;

   localparam logic [3:0] ALU_OP_ADD     = 4'b1001;
   localparam logic [3:0] ALU_OP_SUB     = 4'b0110;
   localparam logic       ALU_MODE_ARITH = 1'b0;

   // alu_16 carry-in is active-low
   localparam logic       ALU_CIN_NONE   = 1'b1;
   localparam logic       ALU_CIN_ONE    = 1'b0;

   localparam logic [3:0] MDS_LAST_STEP  = 4'd15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } mds_state_t;

endpackage

// File: rtl/mul_div_seq.sv
// Sequential 16x16 unsigned multiply / 16/16 restoring divide.
// All add/subtract work is done by the external alu_16 this block drives.
//
// state | meaning
// IDLE  | waiting for start; ALU parked on idle values
// MUL   | 16 shift-add steps over {acc, mq}
// DIV   | 16 restoring-divide steps over {rem, q}
// DONE  | one-cycle done pulse, results valid
module mul_div_seq
   import eclair_alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             div_by_zero,
   output logic [3:0]       alu_op,
   output logic             alu_mode,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic             alu_c_in,
   input  logic [WIDTH-1:0] alu_z,
   input  logic             alu_c_out16
);

   mds_state_t       r_state;
   mds_state_t       w_state_nxt;
   logic [3:0]       r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_hi;      // acc (multiply) / rem (divide)
   logic [WIDTH-1:0] r_lo;      // mq  (multiply) / q   (divide)
   logic [WIDTH-1:0] r_res_hi;
   logic [WIDTH-1:0] r_res_lo;
   logic             r_dbz;

   logic             w_accept;
   logic             w_start_dbz;
   logic             w_last;
   logic             w_ge;
   logic [WIDTH-1:0] w_div_x;
   logic [WIDTH-1:0] w_mul_hi;
   logic [WIDTH-1:0] w_mul_lo;
   logic [WIDTH-1:0] w_div_hi;
   logic [WIDTH-1:0] w_div_lo;

   assign w_accept    = (r_state == IDLE) && start;
   assign w_start_dbz = op && (b == '0);
   assign w_last      = (r_cnt == MDS_LAST_STEP);

   assign w_mul_hi = {~alu_c_out16, alu_z[WIDTH-1:1]};
   assign w_mul_lo = {alu_z[0], r_lo[WIDTH-1:1]};

   // rem[15] set means the shifted partial remainder exceeds 16 bits, so it is >= b
   assign w_div_x  = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
   assign w_ge     = r_hi[WIDTH-1] | ~alu_c_out16;
   assign w_div_hi = w_ge ? alu_z : w_div_x;
   assign w_div_lo = {r_lo[WIDTH-2:0], w_ge};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (w_start_dbz) begin
                  w_state_nxt = DONE;
               end else if (op) begin
                  w_state_nxt = DIV;
               end else begin
                  w_state_nxt = MUL;
               end
            end
         end
         MUL:     if (w_last) w_state_nxt = DONE;
         DIV:     if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = (r_state != IDLE);
      done     = (r_state == DONE);
      alu_op   = ALU_OP_ADD;
      alu_mode = ALU_MODE_ARITH;
      alu_x    = '0;
      alu_y    = '0;
      alu_c_in = ALU_CIN_NONE;
      case (r_state)
         MUL: begin
            alu_x = r_hi;
            alu_y = r_lo[0] ? r_a : '0;
         end
         DIV: begin
            alu_op   = ALU_OP_SUB;
            alu_x    = w_div_x;
            alu_y    = r_b;
            alu_c_in = ALU_CIN_ONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_res_hi <= '0;
         r_res_lo <= '0;
         r_dbz    <= 1'b0;
      end else if (w_accept) begin
         r_cnt <= '0;
         r_a   <= a;
         r_b   <= b;
         r_hi  <= '0;
         r_lo  <= op ? a : b;
         r_dbz <= w_start_dbz;
         if (w_start_dbz) begin
            r_res_hi <= a;
            r_res_lo <= '1;
         end
      end else if (r_state == MUL) begin
         r_cnt <= r_cnt + 4'd1;
         r_hi  <= w_mul_hi;
         r_lo  <= w_mul_lo;
         if (w_last) begin
            r_res_hi <= w_mul_hi;
            r_res_lo <= w_mul_lo;
         end
      end else if (r_state == DIV) begin
         r_cnt <= r_cnt + 4'd1;
         r_hi  <= w_div_hi;
         r_lo  <= w_div_lo;
         if (w_last) begin
            r_res_hi <= w_div_hi;
            r_res_lo <= w_div_lo;
         end
      end
   end

   assign result_hi   = r_res_hi;
   assign result_lo   = r_res_lo;
   assign div_by_zero = r_dbz;

endmodule
